// File: rtl/wisc_pkg.sv
// wisc_pkg: constants and types shared by the phase-2 pipeline stages
// (opcodes, fetch state encoding, IF/ID record layout).
package wisc_pkg;

  localparam logic [3:0]  OPC_HLT        = 4'hF;
  localparam logic [15:0] NOP_INSTR_DFLT = 16'h0000;
  localparam logic [15:0] PC_STEP        = 16'h0002;

  localparam logic [1:0] FETCH_ST = 2'd0;
  localparam logic [1:0] DRAIN_ST = 2'd1;
  localparam logic [1:0] HALT_ST  = 2'd2;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] next_pc;
    logic [15:0] instr;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cla_16bit.sv
// cla_16bit: 16-bit adder/subtractor built from four 4-bit carry-lookahead groups.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        ovfl
);

  logic [15:0] b_eff;
  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;

  assign b_eff = b ^ {16{sub}};
  assign g     = a & b_eff;
  assign p     = a ^ b_eff;
  assign c[0]  = sub;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
  end

  assign sum  = p ^ c[15:0];
  assign ovfl = (a[15] == b_eff[15]) && (sum[15] != a[15]);

endmodule

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc, pc+2, instr} holding register that catches a
// fetched word while decode is stalled. Clear wins over load; load wins over drain.
module fetch_skid_buf
  import wisc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [IF_ID_W-1:0] din,
  output logic               full,
  output logic [IF_ID_W-1:0] dout
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     full <= 1'b0;
    else if (clear) full <= 1'b1 ^ 1'b1;
    else if (load)  full <= 1'b1;
    else if (drain) full <= 1'b0;
  end

  // NOTE: the payload is deliberately not reset; full qualifies it, so its value is never observed stale.
  always_ff @(posedge clk) begin
    if (load) dout <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, instruction-memory request handshake and IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_fd,
  input  logic        flush_fd,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_data_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] curr_pc_fd,
  output logic [15:0] next_pc_fd,
  output logic [15:0] curr_instr_fd,
  output logic        valid_fd,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] drain_addr;
  logic [15:0] pc_plus2;
  logic        pc_ovfl_unused;
  logic        req_en;

  logic        xfer;
  logic        fetch_xfer;
  logic        is_hlt;
  logic        skid_full;
  logic        ifid_from_skid;
  logic        ifid_from_mem;
  logic        skid_load;
  if_id_t      fetch_word;
  if_id_t      skid_word;

  cla_16bit u_pc_inc (
    .a    (pc),
    .b    (PC_STEP),
    .sub  (1'b0),
    .sum  (pc_plus2),
    .ovfl (pc_ovfl_unused)
  );

  assign xfer       = imem_req && imem_data_valid;
  assign fetch_xfer = xfer && (state == FETCH_ST);
  assign is_hlt     = (imem_data[15:12] == OPC_HLT);
  assign fetch_word = '{pc: pc, next_pc: pc_plus2, instr: imem_data};

  // A full skid drains first; a word arriving that cycle refills it so order is kept.
  assign ifid_from_skid = !flush_fd && !stall_fd && skid_full;
  assign ifid_from_mem  = !flush_fd && !stall_fd && !skid_full && fetch_xfer;
  assign skid_load      = !flush_fd && fetch_xfer && !ifid_from_mem;

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .drain (ifid_from_skid),
    .clear (flush_fd),
    .din   (fetch_word),
    .full  (skid_full),
    .dout  (skid_word)
  );

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    imem_req = 1'b0;
    if (req_en) begin
      case (state)
        FETCH_ST: imem_req = !skid_full || !stall_fd;
        DRAIN_ST: imem_req = 1'b1;
        default:  imem_req = 1'b0;
      endcase
    end
  end

  assign imem_addr = (state == DRAIN_ST) ? drain_addr : pc;
  assign halted    = (state == HALT_ST);

  // req_en keeps imem_req low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_en <= 1'b0;
    else        req_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH_ST;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      case (state)
        FETCH_ST: begin
          if (flush_fd) begin
            pc         <= branch_target;
            drain_addr <= pc;
            state      <= (imem_req && !xfer) ? DRAIN_ST : FETCH_ST;
          end else if (fetch_xfer) begin
            if (is_hlt) state <= HALT_ST;
            else        pc    <= pc_plus2;
          end
        end
        DRAIN_ST: begin
          if (flush_fd) pc <= branch_target;
          if (xfer)     state <= FETCH_ST;
        end
        HALT_ST: begin
          if (flush_fd) begin
            pc    <= branch_target;
            state <= FETCH_ST;
          end
        end
        default: state <= FETCH_ST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curr_pc_fd    <= 16'h0000;
      next_pc_fd    <= 16'h0000;
      curr_instr_fd <= NOP_INSTR;
      valid_fd      <= 1'b0;
    end else if (flush_fd) begin
      curr_instr_fd <= NOP_INSTR;
      valid_fd      <= 1'b0;
    end else if (!stall_fd) begin
      if (ifid_from_skid) begin
        curr_pc_fd    <= skid_word.pc;
        next_pc_fd    <= skid_word.next_pc;
        curr_instr_fd <= skid_word.instr;
        valid_fd      <= 1'b1;
      end else if (ifid_from_mem) begin
        curr_pc_fd    <= fetch_word.pc;
        next_pc_fd    <= fetch_word.next_pc;
        curr_instr_fd <= fetch_word.instr;
        valid_fd      <= 1'b1;
      end else begin
        curr_instr_fd <= NOP_INSTR;
        valid_fd      <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 16'h0000;
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (ifid_from_skid || ifid_from_mem) fetch_cnt <= sat_inc16(fetch_cnt);
      if (stall_fd)                        stall_cnt <= sat_inc16(stall_cnt);
      if (flush_fd)                        flush_cnt <= sat_inc16(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: cycle-by-cycle directed vectors for fetch_stage, plus an
// asynchronous mid-run reset sequence.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_fd;
  logic        flush_fd;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_data_valid;
  logic [15:0] imem_data;
  logic [15:0] curr_pc_fd;
  logic [15:0] next_pc_fd;
  logic [15:0] curr_instr_fd;
  logic        valid_fd;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_fd        (stall_fd),
    .flush_fd        (flush_fd),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_data_valid (imem_data_valid),
    .imem_data       (imem_data),
    .curr_pc_fd      (curr_pc_fd),
    .next_pc_fd      (next_pc_fd),
    .curr_instr_fd   (curr_instr_fd),
    .valid_fd        (valid_fd),
    .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] tgt;
    logic        dv;
    logic [15:0] data;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_cpc;
    logic [15:0] exp_npc;
    logic [15:0] exp_instr;
    logic        exp_halt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic f, input logic [15:0] t,
                              input logic dv, input logic [15:0] d,
                              input logic rq, input logic [15:0] ad,
                              input logic v, input logic [15:0] cpc, input logic [15:0] npc,
                              input logic [15:0] ins, input logic h);
    vec_t r;
    r.stall = s;  r.flush = f;  r.tgt = t;  r.dv = dv;  r.data = d;
    r.exp_req = rq;  r.exp_addr = ad;  r.exp_valid = v;
    r.exp_cpc = cpc; r.exp_npc = npc;  r.exp_instr = ins;  r.exp_halt = h;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check request outputs, then check IF/ID after the posedge.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    stall_fd        = v.stall;
    flush_fd        = v.flush;
    branch_target   = v.tgt;
    imem_data_valid = v.dv;
    imem_data       = v.data;
    #1;
    check({tag, ".imem_req"}, 16'(imem_req), 16'(v.exp_req));
    if (v.exp_req) check({tag, ".imem_addr"}, imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
    check({tag, ".valid_fd"},      16'(valid_fd), 16'(v.exp_valid));
    check({tag, ".curr_pc_fd"},    curr_pc_fd,    v.exp_cpc);
    check({tag, ".next_pc_fd"},    next_pc_fd,    v.exp_npc);
    check({tag, ".curr_instr_fd"}, curr_instr_fd, v.exp_instr);
    check({tag, ".halted"},        16'(halted),   16'(v.exp_halt));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".imem_req"},      16'(imem_req), 16'h0);
    check({tag, ".valid_fd"},      16'(valid_fd), 16'h0);
    check({tag, ".halted"},        16'(halted),   16'h0);
    check({tag, ".curr_pc_fd"},    curr_pc_fd,    16'h0000);
    check({tag, ".next_pc_fd"},    next_pc_fd,    16'h0000);
    check({tag, ".curr_instr_fd"}, curr_instr_fd, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0;  stall_fd = 1'b0;  flush_fd = 1'b0;  branch_target = 16'h0000;
    imem_data_valid = 1'b0;  imem_data = 16'h0000;

    //              stall flush tgt       dv  data      req addr      v  cpc       npc       instr     halt
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0)); // c0 first cycle: no request yet
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1000, 1, 16'h0000, 1, 16'h0000, 16'h0002, 16'h1000, 0)); // c1 1-cycle memory
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1002, 1, 16'h0002, 1, 16'h0002, 16'h0004, 16'h1002, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1004, 1, 16'h0004, 1, 16'h0004, 16'h0006, 16'h1004, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 16'h1006, 1, 16'h0006, 1, 16'h0004, 16'h0006, 16'h1004, 0)); // c4 stall: 0006 -> skid
    vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 1, 16'h0004, 16'h0006, 16'h1004, 0)); // skid full -> no req
    vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 1, 16'h0004, 16'h0006, 16'h1004, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 1, 16'h0004, 16'h0006, 16'h1004, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1008, 1, 16'h0008, 1, 16'h0006, 16'h0008, 16'h1006, 0)); // c8 release: skid drains
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h000A, 1, 16'h0008, 16'h000A, 16'h1008, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h000A, 0, 16'h0008, 16'h000A, 16'h0000, 0)); // c10 read of 000A pending
    vecs.push_back(mk(0, 1, 16'h0040, 0, 16'h0000, 1, 16'h000A, 0, 16'h0008, 16'h000A, 16'h0000, 0)); // c11 flush -> drain
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h100A, 1, 16'h000A, 0, 16'h0008, 16'h000A, 16'h0000, 0)); // stale data discarded
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 16'h0008, 16'h000A, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1040, 1, 16'h0040, 1, 16'h0040, 16'h0042, 16'h1040, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0042, 0, 16'h0040, 16'h0042, 16'h0000, 0)); // c15 3-cycle latency
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0042, 0, 16'h0040, 16'h0042, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1042, 1, 16'h0042, 1, 16'h0042, 16'h0044, 16'h1042, 0));
    vecs.push_back(mk(0, 1, 16'h0010, 1, 16'h1044, 1, 16'h0044, 0, 16'h0042, 16'h0044, 16'h0000, 0)); // c18 flush beats transfer
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hF000, 1, 16'h0010, 1, 16'h0010, 16'h0012, 16'hF000, 1)); // c19 HLT
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 0, 16'h0010, 16'h0012, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1111, 0, 16'h0010, 0, 16'h0010, 16'h0012, 16'h0000, 1));
    vecs.push_back(mk(0, 1, 16'h0020, 0, 16'h0000, 0, 16'h0010, 0, 16'h0010, 16'h0012, 16'h0000, 0)); // c22 flush leaves HALT
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1020, 1, 16'h0020, 1, 16'h0020, 16'h0022, 16'h1020, 0));
    vecs.push_back(mk(0, 1, 16'hFFFC, 1, 16'h1022, 1, 16'h0022, 0, 16'h0020, 16'h0022, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1FFC, 1, 16'hFFFC, 1, 16'hFFFC, 16'hFFFE, 16'h1FFC, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1FFE, 1, 16'hFFFE, 1, 16'hFFFE, 16'h0000, 16'h1FFE, 0)); // c26 wrap
    vecs.push_back(mk(1, 1, 16'h0080, 0, 16'h0000, 1, 16'h0000, 0, 16'hFFFE, 16'h0000, 16'h0000, 0)); // c27 stall+flush
    vecs.push_back(mk(0, 1, 16'h00C0, 0, 16'h0000, 1, 16'h0000, 0, 16'hFFFE, 16'h0000, 16'h0000, 0)); // c28 flush in drain
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1234, 1, 16'h0000, 0, 16'hFFFE, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h10C0, 1, 16'h00C0, 1, 16'h00C0, 16'h00C2, 16'h10C0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 16'hF000, 1, 16'h00C2, 1, 16'h00C0, 16'h00C2, 16'h10C0, 1)); // c31 HLT into skid
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h00C2, 1, 16'h00C2, 16'h00C4, 16'hF000, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h00C2, 0, 16'h00C2, 16'h00C4, 16'h0000, 1));

    // Reset state, then release just after an edge so row 0 sees the first post-reset cycle.
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset asserted mid-cycle from the halted state.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    stall_fd = 1'b0;  flush_fd = 1'b0;  imem_data_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_vec(mk(0, 0, 16'h0000, 1, 16'h2000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0), "rst_seq0");
    run_vec(mk(0, 0, 16'h0000, 1, 16'h2000, 1, 16'h0000, 1, 16'h0000, 16'h0002, 16'h2000, 0), "rst_seq1");
    run_vec(mk(0, 0, 16'h0000, 1, 16'h2002, 1, 16'h0002, 1, 16'h0002, 16'h0004, 16'h2002, 0), "rst_seq2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
